// File: rtl/writeback_queue.sv
// Writeback stage: result select, load extraction and an in-order retire queue
// with youngest-write forwarding. Optional perf counters under WB_PERF_EN.
module writeback_queue #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [AW-1:0]   in_dst,
  input  logic            in_wen,
  input  logic [1:0]      in_wsel,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_memdata,
  input  logic [1:0]      in_msize,
  input  logic            in_munsigned,
  input  logic [2:0]      in_addr_lo,
  output logic            commit_valid,
  input  logic            commit_ready,
  output logic [XLEN-1:0] commit_pc,
  output logic            rf_wen,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            fwd_valid,
  output logic [AW-1:0]   fwd_addr,
  output logic [XLEN-1:0] fwd_data,
  output logic [CW-1:0]   count
`ifdef WB_PERF_EN
  ,
  output logic [63:0]     instret,
  output logic [63:0]     wb_stall
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never depends on ready, in_ready may depend on commit_ready.
  logic            push;
  logic            pop;

  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [AW-1:0]   dst_q [DEPTH];
  logic [XLEN-1:0] wd_q  [DEPTH];
  logic            wen_q [DEPTH];

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [5:0]      shamt;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] wd_d;
  logic            wen_d;

  assign commit_valid = reset & (count_q != '0);
  assign pop          = commit_valid & commit_ready;
  assign in_ready     = reset & ((count_q < DEPTH_C) | pop);
  assign push         = in_valid & in_ready;

  // One shifter serves every load size; the case below only picks the width.
  always_comb begin
    shamt = 6'd0;
    case (in_msize)
      2'b00:   shamt = {in_addr_lo, 3'b000};
      2'b01:   shamt = {in_addr_lo[2:1], 4'b0000};
      2'b10:   shamt = {in_addr_lo[2], 5'b00000};
      default: shamt = 6'd0;
    endcase
    lane = in_memdata >> shamt;
    case (in_msize)
      2'b00:   load_ext = {{(XLEN-8){~in_munsigned & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{(XLEN-16){~in_munsigned & lane[15]}}, lane[15:0]};
      2'b10:   load_ext = {{(XLEN-32){~in_munsigned & lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
    case (in_wsel)
      2'b01:   wd_d = load_ext;
      2'b10:   wd_d = in_pc + XLEN'(4);
      default: wd_d = in_result;
    endcase
    wen_d = in_wen & (in_dst != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr_q]  <= in_pc;
      dst_q[wr_ptr_q] <= in_dst;
      wd_q[wr_ptr_q]  <= wd_d;
      wen_q[wr_ptr_q] <= wen_d;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign count     = count_q;
  assign commit_pc = pc_q[rd_ptr_q];
  assign rf_wa     = dst_q[rd_ptr_q];
  assign rf_wd     = wd_q[rd_ptr_q];
  assign rf_wen    = pop & wen_q[rd_ptr_q];

  // Walk oldest to youngest so a later match overrides an earlier one.
  logic [PW:0] idx;
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = {1'b0, rd_ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(DEPTH)) idx = idx - (PW+1)'(DEPTH);
      if ((CW'(i) < count_q) && wen_q[idx[PW-1:0]]) begin
        fwd_valid = 1'b1;
        fwd_addr  = dst_q[idx[PW-1:0]];
        fwd_data  = wd_q[idx[PW-1:0]];
      end
    end
  end

`ifdef WB_PERF_EN
  logic [63:0] instret_q, instret_d;
  logic [63:0] wb_stall_q, wb_stall_d;

  always_comb begin
    instret_d  = instret_q + {63'd0, pop};
    wb_stall_d = wb_stall_q + {63'd0, in_valid & ~in_ready};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instret_q  <= '0;
      wb_stall_q <= '0;
    end else begin
      instret_q  <= instret_d;
      wb_stall_q <= wb_stall_d;
    end
  end

  assign instret  = instret_q;
  assign wb_stall = wb_stall_q;
`endif

endmodule
